icache_line_fill: RTL and testbench



---
 rtl/icache_line_fill.sv | 164 ++++++++++++++++
 tb/tb_icache_line_fill.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Direct-mapped read-only I-cache: hits are served combinationally, misses fetch one 4-beat line.
// Latency: hit 0 cycles; miss = 1 detect + burst beats + 1 DONE, then the re-presented fetch hits.
// Backpressure: o_Stall holds fetch; burst beats accepted whenever i_MEM_Valid. ICACHE_STATS_EN adds counters.
module icache_line_fill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 21,
    parameter int INDEX_BITS    = 6,
    parameter int OFFSET_BITS   = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Fetch_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Fetch_Address,
    output logic [DATA_WIDTH-1:0]    o_Fetch_Data,
    output logic                     o_Stall,
    input  logic                     i_Flush,
    output logic                     o_MEM_Valid,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    output logic                     o_Fill_Error
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              o_Hit_Count,
    output logic [31:0]              o_Miss_Count
`endif
);

    localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int LINE_WORDS = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    logic [LINES-1:0]              r_valid;
    logic [TAG_BITS-1:0]           r_tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]         r_data_mem [LINES*LINE_WORDS];
    logic [ADDRESS_WIDTH-1:0]      r_base;
    logic [OFFSET_BITS-1:0]        r_beat;
    logic                          r_mem_valid;
    logic                          r_flushed;
    logic                          r_fill_error;

    logic [TAG_BITS-1:0]           w_tag;
    logic [INDEX_BITS-1:0]         w_index;
    logic [OFFSET_BITS-1:0]        w_offset;
    logic [INDEX_BITS-1:0]         w_fill_index;
    logic [TAG_BITS-1:0]           w_fill_tag;
    logic                          w_idle;
    logic                          w_tag_hit;
    logic                          w_hit;
    logic                          w_miss;
    logic                          w_beat;
    logic                          w_last;

    assign w_tag        = i_Fetch_Address[ADDRESS_WIDTH-1 -: TAG_BITS];
    assign w_index      = i_Fetch_Address[OFFSET_BITS +: INDEX_BITS];
    assign w_offset     = i_Fetch_Address[OFFSET_BITS-1:0];
    assign w_fill_index = r_base[OFFSET_BITS +: INDEX_BITS];
    assign w_fill_tag   = r_base[ADDRESS_WIDTH-1 -: TAG_BITS];

    // A flush masks a same-cycle hit; a genuine tag miss still launches its fill.
    assign w_idle    = (r_state == S_IDLE);
    assign w_tag_hit = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_hit     = w_idle && i_Fetch_Valid && w_tag_hit && !i_Flush;
    assign w_miss    = w_idle && i_Fetch_Valid && !w_tag_hit;
    assign w_beat    = (r_state == S_FILL) && i_MEM_Valid;
    assign w_last    = w_beat && i_MEM_Last;

    assign o_Stall       = !w_idle || (i_Fetch_Valid && !w_hit);
    assign o_Fetch_Data  = r_data_mem[{w_index, w_offset}];
    assign o_MEM_Valid   = r_mem_valid;
    assign o_MEM_Address = r_base;
    assign o_Fill_Error  = r_fill_error;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state      <= S_IDLE;
            r_mem_valid  <= 1'b0;
            r_base       <= '0;
            r_beat       <= '0;
            r_flushed    <= 1'b0;
            r_fill_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state     <= S_FILL;
                        r_mem_valid <= 1'b1;
                        r_base      <= {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                        r_beat      <= '0;
                        r_flushed   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (i_Flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (i_MEM_Valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (i_MEM_Last) begin
                            r_state     <= S_DONE;
                            r_mem_valid <= 1'b0;
                            if (r_beat != OFFSET_BITS'(LINE_WORDS - 1)) begin
                                r_fill_error <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flush wins over the valid-set of a completing fill, including on the Last beat itself.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_valid <= '0;
        end else if (i_Flush) begin
            r_valid <= '0;
        end else if (w_last && !r_flushed) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_beat) begin
            r_data_mem[{w_fill_index, r_beat}] <= i_MEM_Data;
        end
        if (w_last) begin
            r_tag_mem[w_fill_index] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_Hit_Count  = r_hit_count;
    assign o_Miss_Count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: directed scenarios plus randomized traffic against a line-level cache model.
module tb_icache_line_fill;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          i_Clk = 1'b0;
    logic          i_Reset_n;
    logic          i_Fetch_Valid;
    logic [AW-1:0] i_Fetch_Address;
    logic [DW-1:0] o_Fetch_Data;
    logic          o_Stall;
    logic          i_Flush;
    logic          o_MEM_Valid;
    logic [AW-1:0] o_MEM_Address;
    logic          i_MEM_Valid;
    logic          i_MEM_Last;
    logic [DW-1:0] i_MEM_Data;
    logic          o_Fill_Error;
`ifdef ICACHE_STATS_EN
    logic [31:0]   o_Hit_Count;
    logic [31:0]   o_Miss_Count;
`endif

    icache_line_fill dut (
        .i_Clk           (i_Clk),
        .i_Reset_n       (i_Reset_n),
        .i_Fetch_Valid   (i_Fetch_Valid),
        .i_Fetch_Address (i_Fetch_Address),
        .o_Fetch_Data    (o_Fetch_Data),
        .o_Stall         (o_Stall),
        .i_Flush         (i_Flush),
        .o_MEM_Valid     (o_MEM_Valid),
        .o_MEM_Address   (o_MEM_Address),
        .i_MEM_Valid     (i_MEM_Valid),
        .i_MEM_Last      (i_MEM_Last),
        .i_MEM_Data      (i_MEM_Data),
        .o_Fill_Error    (o_Fill_Error)
`ifdef ICACHE_STATS_EN
        ,
        .o_Hit_Count     (o_Hit_Count),
        .o_Miss_Count    (o_Miss_Count)
`endif
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: a table of lines, plus "a fill is pending for base X" and "one settle cycle".
    bit          m_valid [64];
    logic [12:0] m_tag   [64];
    logic [31:0] m_data  [64][4];
    bit          m_known [64][4];
    bit          m_filling, m_done, m_flushed, m_err;
    int          m_cnt;
    logic [20:0] m_base;
    logic [31:0] m_hits, m_misses;

    function automatic bit m_idle();
        return !m_filling && !m_done;
    endfunction

    function automatic bit m_lookup(input logic [20:0] a);
        return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[20:8]);
    endfunction

    function automatic void m_invalidate_all();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endfunction

    initial begin
        m_filling = 0; m_done = 0; m_flushed = 0; m_err = 0; m_cnt = 0;
        m_base = '0; m_hits = '0; m_misses = '0;
        forever begin
            @(posedge i_Clk or negedge i_Reset_n);
            if (!i_Reset_n) begin
                m_invalidate_all();
                m_filling = 0; m_done = 0; m_err = 0; m_cnt = 0;
                m_hits = '0; m_misses = '0;
            end else if (m_done) begin
                if (i_Flush) m_invalidate_all();
                m_done = 0;
            end else if (m_filling) begin
                if (i_Flush) begin
                    m_invalidate_all();
                    m_flushed = 1;
                end
                if (i_MEM_Valid) begin
                    m_data[m_base[7:2]][m_cnt % 4]  = i_MEM_Data;
                    m_known[m_base[7:2]][m_cnt % 4] = 1'b1;
                    if (i_MEM_Last) begin
                        if ((m_cnt % 4) != 3) m_err = 1;
                        m_tag[m_base[7:2]] = m_base[20:8];
                        if (!m_flushed) m_valid[m_base[7:2]] = 1'b1;
                        m_filling = 0;
                        m_done    = 1;
                    end
                    m_cnt++;
                end
            end else begin
                bit hit;
                hit = m_lookup(i_Fetch_Address);
                if (i_Fetch_Valid && hit && !i_Flush) m_hits++;
                if (i_Flush) m_invalidate_all();
                if (i_Fetch_Valid && !hit) begin
                    m_base    = {i_Fetch_Address[20:2], 2'b00};
                    m_cnt     = 0;
                    m_flushed = 0;
                    m_filling = 1;
                    m_misses++;
                end
            end
        end
    end

    // Every cycle out of reset, compare all meaningful outputs against the model.
    initial begin
        forever begin
            @(negedge i_Clk);
            if (i_Reset_n) begin
                bit e_stall;
                e_stall = !m_idle() ||
                          (i_Fetch_Valid && (!m_lookup(i_Fetch_Address) || i_Flush));
                check("stall", {31'd0, o_Stall}, {31'd0, e_stall});
                check("mem_valid", {31'd0, o_MEM_Valid}, {31'd0, m_filling});
                if (m_filling) check("mem_addr", {11'd0, o_MEM_Address}, {11'd0, m_base});
                check("fill_error", {31'd0, o_Fill_Error}, {31'd0, m_err});
                if (i_Fetch_Valid && !e_stall &&
                    m_known[i_Fetch_Address[7:2]][i_Fetch_Address[1:0]])
                    check("fetch_data", o_Fetch_Data,
                          m_data[i_Fetch_Address[7:2]][i_Fetch_Address[1:0]]);
`ifdef ICACHE_STATS_EN
                check("hit_count", o_Hit_Count, m_hits);
                check("miss_count", o_Miss_Count, m_misses);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Drives a burst while the DUT is filling; returns in the DONE cycle.
    task automatic fill(input logic [31:0] d0, input int nbeats, input bit gaps, input bit flush_last);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && b > 0) begin
                i_MEM_Valid = 1'b0;
                i_MEM_Last  = 1'b1;
                tick();
            end
            i_MEM_Valid = 1'b1;
            i_MEM_Data  = d0 + 32'(b);
            i_MEM_Last  = (b == nbeats - 1);
            i_Flush     = flush_last && (b == nbeats - 1);
            tick();
        end
        i_MEM_Valid = 1'b0;
        i_MEM_Last  = 1'b0;
        i_Flush     = 1'b0;
    endtask

    task automatic miss_fill(input logic [20:0] a, input logic [31:0] d0, input int nbeats,
                             input bit gaps, input bit flush_last);
        i_Fetch_Valid   = 1'b1;
        i_Fetch_Address = a;
        #1 check("miss_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        check("burst_addr", {11'd0, o_MEM_Address}, {11'd0, a[20:2], 2'b00});
        fill(d0, nbeats, gaps, flush_last);
        tick();
    endtask

    initial begin
        int beats_sent, burst_len;
        i_Reset_n = 1'b0; i_Fetch_Valid = 1'b0; i_Fetch_Address = '0; i_Flush = 1'b0;
        i_MEM_Valid = 1'b0; i_MEM_Last = 1'b0; i_MEM_Data = '0;
        #1;
        check("rst_mem_valid", {31'd0, o_MEM_Valid}, 32'd0);
        check("rst_stall", {31'd0, o_Stall}, 32'd0);
        check("rst_fill_error", {31'd0, o_Fill_Error}, 32'd0);
        tick(); tick();
        i_Reset_n = 1'b1;
        tick();

        // Basic miss, 4-beat fill, then zero-cycle hits.
        i_Fetch_Valid = 1'b1; i_Fetch_Address = 21'h000010;
        #1 check("first_miss_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        check("first_mem_valid", {31'd0, o_MEM_Valid}, 32'd1);
        check("first_mem_addr", {11'd0, o_MEM_Address}, 32'h10);
        fill(32'hA0, 4, 1'b0, 1'b0);
        check("done_stall", {31'd0, o_Stall}, 32'd1);
        check("done_mem_valid", {31'd0, o_MEM_Valid}, 32'd0);
        tick();
        check("hit_stall", {31'd0, o_Stall}, 32'd0);
        check("hit_data0", o_Fetch_Data, 32'hA0);
        i_Fetch_Address = 21'h000013;
        #1 check("hit_data3", o_Fetch_Data, 32'hA3);
        check("hit3_stall", {31'd0, o_Stall}, 32'd0);
        tick();

        // Conflict miss on the same index, then a gapped refill of the evicted line.
        miss_fill(21'h000110, 32'hB0, 4, 1'b0, 1'b0);
        check("conflict_hit", o_Fetch_Data, 32'hB0);
        i_Fetch_Address = 21'h000010;
        #1 check("refetch_evicted_stall", {31'd0, o_Stall}, 32'd1);
        tick();
        fill(32'hC0, 4, 1'b1, 1'b0);
        tick();
        i_Fetch_Address = 21'h000012;
        #1 check("gapped_data2", o_Fetch_Data, 32'hC2);
        tick();

        // Flush on the Last beat leaves the line invalid.
        miss_fill(21'h000020, 32'hD0, 4, 1'b0, 1'b1);
        check("flush_last_refetch", {31'd0, o_Stall}, 32'd1);
        tick();
        fill(32'hE0, 4, 1'b0, 1'b0);
        tick();
        check("after_flush_refill", o_Fetch_Data, 32'hE0);

        // Short burst with a mid-fill address change.
        i_Fetch_Address = 21'h000030;
        tick();
        i_MEM_Valid = 1'b1; i_MEM_Data = 32'hF0; tick();
        i_Fetch_Address = 21'h000031;
        i_MEM_Data = 32'hF1; #1 check("addr_change_ignored", {11'd0, o_MEM_Address}, 32'h30);
        tick();
        i_MEM_Data = 32'hF2; i_MEM_Last = 1'b1; tick();
        i_MEM_Valid = 1'b0; i_MEM_Last = 1'b0;
        check("short_burst_error", {31'd0, o_Fill_Error}, 32'd1);
        tick();
        check("short_line_hit", o_Fetch_Data, 32'hF1);
        tick(); tick();
        check("error_sticky", {31'd0, o_Fill_Error}, 32'd1);

        // Reset in the middle of a burst.
        i_Fetch_Address = 21'h000040;
        tick();
        i_MEM_Valid = 1'b1; i_MEM_Data = 32'h50; tick();
        i_MEM_Data = 32'h51;
        #2 i_Reset_n = 1'b0;
        #1 check("reset_drops_mem_valid", {31'd0, o_MEM_Valid}, 32'd0);
        i_MEM_Valid = 1'b0;
        tick();
        i_Reset_n = 1'b1;
        #1 check("post_reset_miss", {31'd0, o_Stall}, 32'd1);
        check("post_reset_error", {31'd0, o_Fill_Error}, 32'd0);
        tick();
        fill(32'h60, 4, 1'b0, 1'b0);
        tick();

        // Randomized traffic: small address pool for hits/conflicts, arbiter with gaps and odd burst lengths.
        beats_sent = 0;
        burst_len  = 4;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (o_MEM_Valid) begin
                if (beats_sent < burst_len && $urandom_range(0, 2) != 0) begin
                    i_MEM_Valid = 1'b1;
                    i_MEM_Data  = $urandom;
                    i_MEM_Last  = (beats_sent == burst_len - 1);
                    beats_sent++;
                end else begin
                    i_MEM_Valid = 1'b0;
                    i_MEM_Last  = 1'($urandom_range(0, 1));
                end
            end else begin
                i_MEM_Valid = 1'b0;
                i_MEM_Last  = 1'b0;
                beats_sent  = 0;
                burst_len   = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 6)) : 4;
            end
            i_Fetch_Valid = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 3) == 0)
                i_Fetch_Address = {13'($urandom_range(0, 2)), 6'($urandom_range(0, 3)),
                                   2'($urandom_range(0, 3))};
            i_Flush = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
